// File: rtl/video_timing_monitor.sv
// Video timing monitor: measures line/frame geometry from the decoded hsync/vsync/de
// stream and declares lock once LOCK_FRAMES consecutive frames measure identically.
module video_timing_monitor #(
  parameter int HW          = 12,
  parameter int VW          = 11,
  parameter int LOCK_FRAMES = 3,
  parameter int TIMEOUT     = 2000000
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          de,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          frame_stb,
  output logic          locked,
  output logic [7:0]    err_cnt,
  output logic [7:0]    led
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [MW-1:0] M_LOCK = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic [HW-1:0] h_sat_inc(input logic [HW-1:0] v);
    return (&v) ? v : v + HW'(1);
  endfunction

  function automatic logic [VW-1:0] v_sat_inc(input logic [VW-1:0] v);
    return (&v) ? v : v + VW'(1);
  endfunction

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [HW-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
  logic [HW-1:0] dcnt_q, dcnt_d, line_act_q, line_act_d;
  logic          act_line_q, act_line_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vact_q, vact_d;
  logic [HW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [VW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic          frame_stb_q, frame_stb_d, locked_q, locked_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          hs_rise, vs_rise, de_fall, same_geom;
  logic [HW-1:0] h_total_new, h_active_new;
  logic [VW-1:0] v_total_new, v_active_new;
  logic [MW-1:0] match_next;
  logic [7:0]    err_next;

  always_comb begin
    hs_rise = hsync & ~hsync_q;
    vs_rise = vsync & ~vsync_q;
    de_fall = ~de & de_q;

    hsync_d     = hsync;
    vsync_d     = vsync;
    de_d        = de;
    hcnt_d      = h_sat_inc(hcnt_q);
    line_len_d  = line_len_q;
    dcnt_d      = dcnt_q;
    line_act_d  = line_act_q;
    act_line_d  = act_line_q;
    vcnt_d      = vcnt_q;
    vact_d      = vact_q;
    h_total_d   = h_total_q;
    h_active_d  = h_active_q;
    v_total_d   = v_total_q;
    v_active_d  = v_active_q;
    frame_stb_d = 1'b0;
    state_d     = state_q;
    match_d     = match_q;
    err_cnt_d   = err_cnt_q;
    timer_d     = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);

    // A line closing in the same cycle as vsync belongs to the frame being latched.
    h_total_new  = hs_rise ? h_sat_inc(hcnt_q) : line_len_q;
    h_active_new = de_fall ? dcnt_q : line_act_q;
    v_total_new  = hs_rise ? v_sat_inc(vcnt_q) : vcnt_q;
    v_active_new = act_line_q ? v_sat_inc(vact_q) : vact_q;
    same_geom    = (h_total_new == h_total_q) && (h_active_new == h_active_q) &&
                   (v_total_new == v_total_q) && (v_active_new == v_active_q);
    match_next   = match_q + MW'(1);
    err_next     = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 8'd1;

    if (hs_rise) begin
      hcnt_d     = '0;
      line_len_d = h_total_new;
      dcnt_d     = {{(HW-1){1'b0}}, de};
      vcnt_d     = v_total_new;
      vact_d     = v_active_new;
    end else if (de) begin
      dcnt_d = h_sat_inc(dcnt_q);
    end
    if (de_fall) line_act_d = dcnt_q;
    if (hs_rise || vs_rise) act_line_d = de;
    else if (de) act_line_d = 1'b1;

    if (vs_rise) begin
      vcnt_d      = '0;
      vact_d      = '0;
      timer_d     = '0;
      frame_stb_d = 1'b1;
      h_total_d   = h_total_new;
      h_active_d  = h_active_new;
      v_total_d   = v_total_new;
      v_active_d  = v_active_new;
      case (state_q)
        ST_UNLOCKED: begin
          state_d = ST_MEASURE;
          match_d = MW'(1);
        end
        ST_MEASURE: begin
          if (same_geom) begin
            match_d = match_next;
            if (match_next == M_LOCK) state_d = ST_LOCKED;
          end else begin
            match_d = MW'(1);
          end
        end
        ST_LOCKED: begin
          if (!same_geom) begin
            state_d   = ST_UNLOCKED;
            err_cnt_d = err_next;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end else if (timer_q == T_LAST) begin
      // Sync lost: drop everything; the timer then parks at T_MAX.
      state_d    = ST_UNLOCKED;
      match_d    = '0;
      h_total_d  = '0;
      h_active_d = '0;
      v_total_d  = '0;
      v_active_d = '0;
      if (state_q == ST_LOCKED) err_cnt_d = err_next;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      hcnt_q      <= '0;
      line_len_q  <= '0;
      dcnt_q      <= '0;
      line_act_q  <= '0;
      act_line_q  <= 1'b0;
      vcnt_q      <= '0;
      vact_q      <= '0;
      h_total_q   <= '0;
      h_active_q  <= '0;
      v_total_q   <= '0;
      v_active_q  <= '0;
      frame_stb_q <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      state_q     <= ST_UNLOCKED;
      match_q     <= '0;
      timer_q     <= '0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      hcnt_q      <= hcnt_d;
      line_len_q  <= line_len_d;
      dcnt_q      <= dcnt_d;
      line_act_q  <= line_act_d;
      act_line_q  <= act_line_d;
      vcnt_q      <= vcnt_d;
      vact_q      <= vact_d;
      h_total_q   <= h_total_d;
      h_active_q  <= h_active_d;
      v_total_q   <= v_total_d;
      v_active_q  <= v_active_d;
      frame_stb_q <= frame_stb_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      state_q     <= state_d;
      match_q     <= match_d;
      timer_q     <= timer_d;
    end
  end

  assign h_total   = h_total_q;
  assign h_active  = h_active_q;
  assign v_total   = v_total_q;
  assign v_active  = v_active_q;
  assign frame_stb = frame_stb_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;
  assign led       = {locked_q, |err_cnt_q, v_active_q[VW-1:VW-6]};

endmodule
